// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD 8080-style write-bus arbiter.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WR_LO = 2'd2,
    ST_WR_HI = 2'd3
  } lcd_state_e;

  localparam logic RS_CMD    = 1'b0;
  localparam logic RS_DATA   = 1'b1;

  localparam logic PORT_INIT = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // Largest of the three phase lengths, used to size the phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_wr_timer.sv
// Loadable down-counter that times one strobe phase; phase_done is high on the
// last cycle of the phase (counter at zero). Holds at zero instead of wrapping.
module lcd_wr_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_done
);

  logic [CNT_W-1:0] cnt_r;

  // Phase counter: reload on state entry, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1'b1);
    end
  end

  assign phase_done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-port arbiter and write-strobe generator for an 8080-style LCD bus.
// Define LCD_ARB_BURST_EN to let the owning port chain beats without an IDLE gap.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SETUP_CYC  = 1,
  parameter int WR_LO_CYC  = 2,
  parameter int WR_HI_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_rs,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_rs,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  init_done,
  output logic                  busy,
  output logic                  LCD_CS,
  output logic                  LCD_RS,
  output logic                  LCD_WR,
  output logic [DATA_WIDTH-1:0] LCD_DATA
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, WR_LO_CYC, WR_HI_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LO_LD = CNT_W'(WR_LO_CYC - 1);
  localparam logic [CNT_W-1:0] WR_HI_LD = CNT_W'(WR_HI_CYC - 1);

  lcd_state_e            state_r;
  logic                  cs_r;
  logic                  wr_r;
  logic                  rs_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  busy_r;
  logic                  rr_r;

  logic                  grant0_s;
  logic                  grant1_s;
  logic                  burst0_s;
  logic                  burst1_s;
  logic                  accept0_s;
  logic                  accept1_s;
  logic                  accept_s;
  logic                  sel_port_s;
  logic                  sel_rs_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  load_s;
  logic [CNT_W-1:0]      load_val_s;
  logic                  phase_done_s;

  // Arbitration: host is locked out until init completes; ties go to rr_r.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid && init_done) begin
      grant0_s = (rr_r == PORT_INIT);
      grant1_s = (rr_r == PORT_HOST);
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid && init_done) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

`ifdef LCD_ARB_BURST_EN
  logic owner_r;

  assign burst0_s = (state_r == ST_WR_HI) && phase_done_s && (owner_r == PORT_INIT) && req0_valid;
  assign burst1_s = (state_r == ST_WR_HI) && phase_done_s && (owner_r == PORT_HOST) &&
                    req1_valid && init_done;
`else
  assign burst0_s = 1'b0;
  assign burst1_s = 1'b0;
`endif

  assign accept0_s  = ((state_r == ST_IDLE) && grant0_s) || burst0_s;
  assign accept1_s  = ((state_r == ST_IDLE) && grant1_s) || burst1_s;
  assign accept_s   = accept0_s || accept1_s;
  assign req0_ready = accept0_s;
  assign req1_ready = accept1_s;

  // Beat mux: pick the accepted port's payload.
  always_comb begin
    sel_port_s = PORT_INIT;
    sel_rs_s   = req0_rs;
    sel_data_s = req0_data;
    if (accept1_s) begin
      sel_port_s = PORT_HOST;
      sel_rs_s   = req1_rs;
      sel_data_s = req1_data;
    end else begin
      sel_port_s = PORT_INIT;
      sel_rs_s   = req0_rs;
      sel_data_s = req0_data;
    end
  end

  // Timer reload on every state entry.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE, ST_WR_HI: begin
        if (accept_s) begin
          load_s     = 1'b1;
          load_val_s = SETUP_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      ST_SETUP: begin
        if (phase_done_s) begin
          load_s     = 1'b1;
          load_val_s = WR_LO_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      ST_WR_LO: begin
        if (phase_done_s) begin
          load_s     = 1'b1;
          load_val_s = WR_HI_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      default: begin
        load_s     = 1'b0;
        load_val_s = {CNT_W{1'b0}};
      end
    endcase
  end

  lcd_wr_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_val  (load_val_s),
    .phase_done(phase_done_s)
  );

  // Bus FSM with registered pad outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cs_r    <= 1'b1;
      wr_r    <= 1'b1;
      rs_r    <= RS_CMD;
      data_r  <= {DATA_WIDTH{1'b0}};
      busy_r  <= 1'b0;
      rr_r    <= PORT_INIT;
`ifdef LCD_ARB_BURST_EN
      owner_r <= PORT_INIT;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_SETUP;
            cs_r    <= 1'b0;
            busy_r  <= 1'b1;
            rs_r    <= sel_rs_s;
            data_r  <= sel_data_s;
            rr_r    <= ~sel_port_s;
`ifdef LCD_ARB_BURST_EN
            owner_r <= sel_port_s;
`endif
          end
        end
        ST_SETUP: begin
          if (phase_done_s) begin
            state_r <= ST_WR_LO;
            wr_r    <= 1'b0;
          end
        end
        ST_WR_LO: begin
          if (phase_done_s) begin
            state_r <= ST_WR_HI;
            wr_r    <= 1'b1;
          end
        end
        ST_WR_HI: begin
          // A burst accept only happens here on the last WR_HI cycle; CS stays low.
          if (accept_s) begin
            state_r <= ST_SETUP;
            rs_r    <= sel_rs_s;
            data_r  <= sel_data_s;
            rr_r    <= ~sel_port_s;
          end else if (phase_done_s) begin
            state_r <= ST_IDLE;
            cs_r    <= 1'b1;
            busy_r  <= 1'b0;
            rs_r    <= RS_CMD;
            data_r  <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cs_r    <= 1'b1;
          wr_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign LCD_CS   = cs_r;
  assign LCD_WR   = wr_r;
  assign LCD_RS   = rs_r;
  assign LCD_DATA = data_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: default-timing instance plus a 1/1/1 timing instance.
module tb_lcd_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_rs = 1'b0, req0_ready;
  logic [15:0] req0_data = 16'h0000;
  logic        req1_valid = 1'b0, req1_rs = 1'b0, req1_ready;
  logic [15:0] req1_data = 16'h0000;
  logic        init_done = 1'b0, busy, LCD_CS, LCD_RS, LCD_WR;
  logic [15:0] LCD_DATA;

  logic        f_req0_valid = 1'b0, f_req0_rs = 1'b0, f_req0_ready;
  logic [15:0] f_req0_data = 16'h0000;
  logic        f_req1_valid = 1'b0, f_req1_rs = 1'b0, f_req1_ready;
  logic [15:0] f_req1_data = 16'h0000;
  logic        f_init_done = 1'b0, f_busy, f_cs, f_rs, f_wr;
  logic [15:0] f_data;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  logic        prev_wr = 1'b1;

  always #5 clk = ~clk;

  lcd_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_DATA(LCD_DATA)
  );

  lcd_bus_arbiter #(.DATA_WIDTH(16), .SETUP_CYC(1), .WR_LO_CYC(1), .WR_HI_CYC(1)) u_fast (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_rs(f_req0_rs), .req0_data(f_req0_data), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_rs(f_req1_rs), .req1_data(f_req1_data), .req1_ready(f_req1_ready),
    .init_done(f_init_done), .busy(f_busy),
    .LCD_CS(f_cs), .LCD_RS(f_rs), .LCD_WR(f_wr), .LCD_DATA(f_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every WR rising edge while CS is low must deliver the next expected beat.
  always @(negedge clk) begin
    if (prev_wr === 1'b0 && LCD_WR === 1'b1 && LCD_CS === 1'b0) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL beat_unexpected observed=%0h expected=none", {LCD_RS, LCD_DATA});
      end
      if (exp_q.size() > 0) chk("beat_data", 32'({LCD_RS, LCD_DATA}), 32'(exp_q.pop_front()));
    end
    prev_wr <= LCD_WR;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p0_d[4];
    logic [15:0] p1_d[4];
    logic cse, wre, r0e, r1e, g0, g1;
    int bad, i0, i1;
    p0_d = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    p1_d = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", 32'({LCD_CS, LCD_WR, LCD_RS, busy, req0_ready, req1_ready}), 32'(6'b110000));
    chk("rst_data", 32'(LCD_DATA), 32'(16'h0000));
    chk("rst_fast", 32'({f_cs, f_wr, f_rs, f_busy}), 32'(4'b1100));

    // Single command beat from port 0
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 16'h002C;
    exp_q.push_back({1'b0, 16'h002C});
    @(negedge clk);
    chk("single_ready", 32'({req0_ready, req1_ready}), 32'(2'b10));
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      cse = (k <= 6) ? 1'b0 : 1'b1;
      wre = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      chk($sformatf("single_c%0d", k), 32'({LCD_CS, LCD_WR, req0_ready, busy}), 32'({cse, wre, 1'b0, ~cse}));
      if (k <= 6) chk($sformatf("single_rsdata_c%0d", k), 32'({LCD_RS, LCD_DATA}), 32'({1'b0, 16'h002C}));
    end

    // Host locked out while init is not done
    @(posedge clk); #1;
    init_done = 1'b0; req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 16'h5555;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (req1_ready !== 1'b0 || req0_ready !== 1'b0 || LCD_CS !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("init_gate", 32'(bad), 32'(0));
    @(posedge clk); #1 req1_valid = 1'b0;

    // Reset during WR_LO abandons the beat
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 16'h1234;
    @(negedge clk);
    chk("rstmid_ready", 32'(req0_ready), 32'(1'b1));
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_wrlo", 32'({LCD_CS, LCD_WR}), 32'(2'b00));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", 32'({LCD_CS, LCD_WR, busy, LCD_RS}), 32'(4'b1100));
    chk("rstmid_data", 32'(LCD_DATA), 32'(16'h0000));
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (LCD_CS !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rstmid_noreplay", 32'(bad), 32'(0));

`ifndef LCD_ARB_BURST_EN
    // Round-robin with both ports continuously valid
    @(posedge clk); #1;
    init_done = 1'b1; i0 = 0; i1 = 0;
    req0_valid = 1'b1; req0_rs = 1'b0; req0_data = p0_d[0];
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = p1_d[0];
    exp_q.push_back({1'b0, p0_d[0]});
    exp_q.push_back({1'b1, p1_d[0]});
    exp_q.push_back({1'b0, p0_d[1]});
    exp_q.push_back({1'b1, p1_d[1]});
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      r0e = (k == 1 || k == 13);
      r1e = (k == 7 || k == 19);
      cse = (k % 6 == 1) ? 1'b1 : 1'b0;
      chk($sformatf("rr_c%0d", k), 32'({req0_ready, req1_ready, LCD_CS}), 32'({r0e, r1e, cse}));
      g0 = req0_ready; g1 = req1_ready;
      @(posedge clk); #1;
      if (g0 === 1'b1) begin i0++; req0_data = p0_d[i0]; end
      if (g1 === 1'b1) begin i1++; req1_data = p1_d[i1]; end
      if (k == 24) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
`else
    // Burst of three host beats with CS held low throughout
    @(posedge clk); #1;
    init_done = 1'b1; i1 = 0;
    p1_d = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000};
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = p1_d[0];
    for (int j = 0; j < 3; j++) exp_q.push_back({1'b1, p1_d[j]});
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      r1e = (k == 1 || k == 6 || k == 11);
      cse = (k == 1 || k == 17) ? 1'b1 : 1'b0;
      wre = (k == 3 || k == 4 || k == 8 || k == 9 || k == 13 || k == 14) ? 1'b0 : 1'b1;
      chk($sformatf("burst_c%0d", k), 32'({req1_ready, LCD_CS, LCD_WR}), 32'({r1e, cse, wre}));
      g1 = req1_ready;
      @(posedge clk); #1;
      if (g1 === 1'b1) begin
        i1++;
        req1_data = p1_d[i1];
        if (i1 == 3) req1_valid = 1'b0;
      end
    end
`endif

    // Minimum timing instance: 4-cycle beat, WR low exactly one cycle
    @(posedge clk); #1;
    f_req0_valid = 1'b1; f_req0_rs = 1'b1; f_req0_data = 16'hABCD;
    @(negedge clk);
    chk("fast_ready", 32'(f_req0_ready), 32'(1'b1));
    @(posedge clk); #1 f_req0_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      cse = (k <= 4) ? 1'b0 : 1'b1;
      wre = (k == 3) ? 1'b0 : 1'b1;
      chk($sformatf("fast_c%0d", k), 32'({f_cs, f_wr, f_busy}), 32'({cse, wre, ~cse}));
      if (k == 3) chk("fast_rsdata", 32'({f_rs, f_data}), 32'({1'b1, 16'hABCD}));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
